// File: rtl/wowi_arbiter.sv
// Round-robin arbiter/sequencer sharing one word-wide BRAM adapter among N_REQ requesters.
// Latches the winner, strobes the adapter once, waits for ready (with timeout), and reports back.
module wowi_arbiter #(
  parameter  int DATA_WIDTH = 8,
  parameter  int WORD_BYTES = 2,
  parameter  int N_REQ      = 2,
  parameter  int TIMEOUT    = 16,
  localparam int W          = WORD_BYTES * DATA_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_write,
  input  logic [N_REQ*8-1:0] req_addr,
  input  logic [N_REQ*W-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   rsp_done,
  output logic [N_REQ-1:0]   rsp_err,
  output logic [W-1:0]       rsp_rdata,
  output logic               busy,
  output logic               ad_st_read,
  output logic               ad_st_write,
  output logic [7:0]         ad_base_addr,
  output logic [W-1:0]       ad_write_data,
  input  logic [W-1:0]       ad_read_data,
  input  logic               ad_ready
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic [7:0]       addr_q, addr_d;
  logic [W-1:0]     wdata_q, wdata_d;
  logic [W-1:0]     rdata_q, rdata_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic [7:0]       addr_arr  [N_REQ];
  logic [W-1:0]     wdata_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign addr_arr[gi]  = req_addr[gi*8 +: 8];
      assign wdata_arr[gi] = req_wdata[gi*W +: W];
    end
  endgenerate

  // Round-robin search starting just after the last served requester.
  logic             found;
  logic [IDX_W-1:0] win;
  logic [IDX_W:0]   cand;

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!found && req_valid[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        win   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    timer_d = timer_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          idx_d   = win;
          write_d = req_write[win];
          addr_d  = addr_arr[win];
          wdata_d = wdata_arr[win];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ad_ready) begin
          state_d = write_q ? S_DONE : S_CAPTURE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      // The adapter's last byte lands on the ready edge, so sample one cycle later.
      S_CAPTURE: begin
        rdata_d = ad_read_data;
        state_d = S_DONE;
      end
      S_DONE: begin
        ptr_d   = idx_q;
        state_d = S_IDLE;
      end
      S_ERR: begin
        ptr_d   = idx_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      idx_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    req_ack     = '0;
    rsp_done    = '0;
    rsp_err     = '0;
    ad_st_read  = 1'b0;
    ad_st_write = 1'b0;
    case (state_q)
      S_ISSUE: begin
        req_ack[idx_q] = 1'b1;
        ad_st_write    = write_q;
        ad_st_read     = !write_q;
      end
      S_DONE:  rsp_done[idx_q] = 1'b1;
      S_ERR:   rsp_err[idx_q]  = 1'b1;
      default: ;
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign ad_base_addr  = addr_q;
  assign ad_write_data = wdata_q;
  assign rsp_rdata     = rdata_q;

endmodule

// File: tb/tb_wowi_arbiter.sv
// Directed bench for wowi_arbiter: reads, writes, fairness, timeout, reset abort, spurious ready.
module tb_wowi_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_write = '0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_ack, rsp_done, rsp_err;
  logic [15:0] rsp_rdata;
  logic        busy, ad_st_read, ad_st_write;
  logic [7:0]  ad_base_addr;
  logic [15:0] ad_write_data;
  logic [15:0] ad_read_data = '0;
  logic        ad_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;

  wowi_arbiter #(.DATA_WIDTH(8), .WORD_BYTES(2), .N_REQ(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_done(rsp_done), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .busy(busy), .ad_st_read(ad_st_read), .ad_st_write(ad_st_write),
    .ad_base_addr(ad_base_addr), .ad_write_data(ad_write_data),
    .ad_read_data(ad_read_data), .ad_ready(ad_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ad_st_read || ad_st_write) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts in the grant (IDLE) cycle; ends in the IDLE cycle after DONE.
  task automatic do_read(input logic [1:0] exp_ack, input logic [15:0] data,
                         input logic [7:0] exp_addr, input logic [1:0] nv);
    cyc();
    chk("rd_ack", 32'(req_ack), 32'(exp_ack));
    chk("rd_strobe", 32'({ad_st_read, ad_st_write}), 2);
    chk("rd_addr", 32'(ad_base_addr), 32'(exp_addr));
    req_valid = nv;
    cyc();
    chk("rd_strobe_once", 32'({ad_st_read, ad_st_write}), 0);
    cyc();
    ad_ready = 1'b1;
    ad_read_data = data & 16'h00FF;
    cyc();
    ad_ready = 1'b0;
    ad_read_data = data;
    chk("rd_early_done", 32'(rsp_done), 0);
    cyc();
    chk("rd_done", 32'(rsp_done), 32'(exp_ack));
    chk("rd_rdata", 32'(rsp_rdata), 32'(data));
    cyc();
    chk("rd_idle", 32'({busy, rsp_done}), 0);
    chk("rd_rdata_held", 32'(rsp_rdata), 32'(data));
  endtask

  task automatic do_write(input logic [1:0] exp_ack, input logic [7:0] exp_addr,
                          input logic [15:0] exp_wdata, input logic [15:0] exp_rdata,
                          input logic [1:0] nv);
    cyc();
    chk("wr_ack", 32'(req_ack), 32'(exp_ack));
    chk("wr_strobe", 32'({ad_st_read, ad_st_write}), 1);
    chk("wr_addr", 32'(ad_base_addr), 32'(exp_addr));
    chk("wr_wdata", 32'(ad_write_data), 32'(exp_wdata));
    req_valid = nv;
    req_wdata = '0;
    req_addr = '0;
    cyc();
    chk("wr_strobe_once", 32'({ad_st_read, ad_st_write}), 0);
    chk("wr_wdata_wait", 32'(ad_write_data), 32'(exp_wdata));
    cyc();
    ad_ready = 1'b1;
    cyc();
    ad_ready = 1'b0;
    chk("wr_done", 32'(rsp_done), 32'(exp_ack));
    chk("wr_wdata_done", 32'(ad_write_data), 32'(exp_wdata));
    chk("wr_rdata_kept", 32'(rsp_rdata), 32'(exp_rdata));
    cyc();
    chk("wr_idle", 32'({busy, rsp_done}), 0);
  endtask

  initial begin
    int s0;
    logic [1:0] seen;

    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_ctrl", 32'({req_ack, rsp_done, rsp_err, busy, ad_st_read, ad_st_write}), 0);
    chk("rst_addr", 32'(ad_base_addr), 0);
    chk("rst_wdata", 32'(ad_write_data), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);

    // Single read from requester 0
    req_valid = 2'b01; req_write = 2'b00; req_addr = {8'h00, 8'h10};
    do_read(2'b01, 16'hBEEF, 8'h10, 2'b00);

    // Write from requester 1
    req_valid = 2'b10; req_write = 2'b10; req_addr = {8'h20, 8'h00};
    req_wdata = {16'h1234, 16'hDEAD};
    do_write(2'b10, 8'h20, 16'h1234, 16'hBEEF, 2'b00);

    // Fairness after reset: both hold valid, reads alternate 0,1,0,1
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_rdata", 32'(rsp_rdata), 0);
    req_valid = 2'b11; req_write = 2'b00; req_addr = {8'h31, 8'h30};
    for (int i = 0; i < 4; i++) begin
      do_read((i % 2) ? 2'b10 : 2'b01, 16'hA000 + 16'(i), (i % 2) ? 8'h31 : 8'h30, 2'b11);
    end

    // Timeout: requester 0 wins, no ready ever
    cyc();
    chk("to_ack", 32'(req_ack), 1);
    seen = '0;
    for (int i = 2; i < 18; i++) begin
      cyc();
      seen = seen | rsp_err | rsp_done;
    end
    chk("to_no_early_rsp", 32'(seen), 0);
    cyc();
    chk("to_err", 32'(rsp_err), 1);
    chk("to_no_done", 32'(rsp_done), 0);
    chk("to_rdata_kept", 32'(rsp_rdata), 32'h0000A003);
    cyc();
    chk("to_idle", 32'({busy, rsp_err}), 0);
    do_read(2'b10, 16'h5A5A, 8'h31, 2'b00);

    // Write from requester 0 so the pointer sits at 0
    req_valid = 2'b01; req_write = 2'b01; req_addr = {8'h00, 8'h40};
    req_wdata = {16'h0000, 16'h7777};
    do_write(2'b01, 8'h40, 16'h7777, 16'h5A5A, 2'b00);

    // Reset mid-WAIT on a read by requester 1
    req_valid = 2'b10; req_write = 2'b00; req_addr = {8'h44, 8'h00};
    cyc();
    chk("rw_ack", 32'(req_ack), 2);
    req_valid = 2'b00;
    cyc();
    chk("rw_busy", 32'(busy), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rw_ctrl", 32'({req_ack, rsp_done, rsp_err, busy, ad_st_read, ad_st_write}), 0);
    chk("rw_addr", 32'(ad_base_addr), 0);
    chk("rw_rdata", 32'(rsp_rdata), 0);
    ad_ready = 1'b1;
    cyc();
    ad_ready = 1'b0;
    chk("rw_late_ready", 32'({busy, rsp_done, rsp_err}), 0);
    cyc();
    chk("rw_late_ready2", 32'({busy, rsp_done, rsp_err}), 0);
    req_valid = 2'b11; req_addr = {8'h51, 8'h50};
    do_read(2'b01, 16'hC3C3, 8'h50, 2'b00);

    // Spurious ready in IDLE and ISSUE
    s0 = strobe_cnt;
    ad_ready = 1'b1;
    cyc();
    chk("sp_idle", 32'({busy, rsp_done}), 0);
    req_valid = 2'b01; req_write = 2'b00; req_addr = {8'h00, 8'h60};
    cyc();
    chk("sp_ack", 32'(req_ack), 1);
    req_valid = 2'b00;
    cyc();
    ad_ready = 1'b0;
    chk("sp_wait", 32'({busy, rsp_done}), 3'b100);
    cyc();
    chk("sp_wait2", 32'({busy, rsp_done}), 3'b100);
    ad_ready = 1'b1;
    ad_read_data = 16'h0066;
    cyc();
    ad_ready = 1'b0;
    ad_read_data = 16'h9966;
    chk("sp_capture", 32'(rsp_done), 0);
    cyc();
    chk("sp_done", 32'(rsp_done), 1);
    chk("sp_rdata", 32'(rsp_rdata), 32'h00009966);
    cyc();
    chk("sp_strobes", 32'(strobe_cnt), 32'(s0 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
